// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Round-robin on contention, one transaction in flight, timeout abort with bus_err.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   owner_t              last_q, last_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req || ls_req) begin
               if (if_req && ls_req) begin
                  owner_d = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
               end else begin
                  owner_d = ls_req ? OWN_LS : OWN_IF;
               end
               // Fetches are forced to full-word reads regardless of the LS payload.
               if (owner_d == OWN_LS) begin
                  we_d    = ls_we;
                  be_d    = ls_be;
                  addr_d  = ls_addr;
                  wdata_d = ls_wdata;
               end else begin
                  we_d    = 1'b0;
                  be_d    = 4'hF;
                  addr_d  = if_addr;
                  wdata_d = '0;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            last_d  = owner_q;
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid || (cnt_q == LAST_CNT)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         last_q  <= OWN_IF;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Outputs are forced low while rst is high, including the cycle before it is sampled.
   always_comb begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_gnt    = 1'b0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = '0;
      bus_err   = 1'b0;
      if (!rst) begin
         mem_we    = we_q;
         mem_be    = be_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
         case (state_q)
            ST_ISSUE: begin
               mem_req = 1'b1;
               if (owner_q == OWN_IF) if_gnt = 1'b1;
               else                   ls_gnt = 1'b1;
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  if (owner_q == OWN_IF) begin
                     if_rvalid = 1'b1;
                     if_rdata  = mem_rdata;
                  end else begin
                     ls_rvalid = 1'b1;
                     ls_rdata  = mem_rdata;
                  end
               end else if (cnt_q == LAST_CNT) begin
                  bus_err = 1'b1;
                  if (owner_q == OWN_IF) if_rvalid = 1'b1;
                  else                   ls_rvalid = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, contention,
// timeout abort, reset mid-transaction and spurious memory completions.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, ls_req, ls_we, mem_rvalid;
   logic [AW-1:0] if_addr, ls_addr;
   logic [3:0]    ls_be;
   logic [DW-1:0] ls_wdata, mem_rdata;
   logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic          mem_req, mem_we, bus_err;
   logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
      check({tag, ".ls_gnt"},    64'(ls_gnt),    64'd0);
      check({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
      check({tag, ".ls_rvalid"}, 64'(ls_rvalid), 64'd0);
      check({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
      check({tag, ".ls_rdata"},  64'(ls_rdata),  64'd0);
      check({tag, ".mem_req"},   64'(mem_req),   64'd0);
      check({tag, ".bus_err"},   64'(bus_err),   64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_quiet(tag);
      check({tag, ".mem_we"},    64'(mem_we),    64'd0);
      check({tag, ".mem_be"},    64'(mem_be),    64'd0);
      check({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
      check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_rvalid = 1'b0;
      if_addr = '0; ls_addr = '0; ls_be = 4'h0; ls_wdata = '0; mem_rdata = '0;

      // Reset, with a stray completion present.
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      #1 check_reset_outputs("rst");
      step();
      rst = 1'b0; mem_rvalid = 1'b0;
      #1 check_reset_outputs("post_rst");

      // Single fetch, data two cycles after mem_req.
      if_req = 1'b1; if_addr = 32'h0000_0040;
      #1 check("fetch.idle_gnt", 64'(if_gnt), 64'd0);
      step();
      #1;
      check("fetch.if_gnt",   64'(if_gnt),   64'd1);
      check("fetch.ls_gnt",   64'(ls_gnt),   64'd0);
      check("fetch.mem_req",  64'(mem_req),  64'd1);
      check("fetch.mem_addr", 64'(mem_addr), 64'h40);
      check("fetch.mem_we",   64'(mem_we),   64'd0);
      check("fetch.mem_be",   64'(mem_be),   64'hF);
      step();
      if_req = 1'b0;
      #1;
      check("fetch.wait_req",    64'(mem_req),   64'd0);
      check("fetch.wait_rvalid", 64'(if_rvalid), 64'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
      #1;
      check("fetch.if_rvalid", 64'(if_rvalid), 64'd1);
      check("fetch.if_rdata",  64'(if_rdata),  64'h0010_0093);
      check("fetch.ls_rvalid", 64'(ls_rvalid), 64'd0);
      check("fetch.ls_rdata",  64'(ls_rdata),  64'd0);
      check("fetch.bus_err",   64'(bus_err),   64'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      check_quiet("fetch.done");
      check("fetch.addr_hold", 64'(mem_addr), 64'h40);

      // Store; a completion during ISSUE must be ignored.
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      #1;
      check("store.ls_gnt",     64'(ls_gnt),    64'd1);
      check("store.if_gnt",     64'(if_gnt),    64'd0);
      check("store.mem_we",     64'(mem_we),    64'd1);
      check("store.mem_be",     64'(mem_be),    64'h3);
      check("store.mem_addr",   64'(mem_addr),  64'h100);
      check("store.mem_wdata",  64'(mem_wdata), 64'hDEAD_BEEF);
      check("store.issue_rval", 64'(ls_rvalid), 64'd0);
      step();
      ls_req = 1'b0; ls_we = 1'b0;
      #1;
      check("store.ls_rvalid", 64'(ls_rvalid), 64'd1);
      check("store.if_rvalid", 64'(if_rvalid), 64'd0);
      check("store.gnt_off",   64'(ls_gnt),    64'd0);
      step();
      mem_rvalid = 1'b0;
      #1 check_quiet("store.done");

      // Contention right after reset: LS, IF, LS, IF.
      rst = 1'b1;
      step();
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h200;
      ls_req = 1'b1; ls_addr = 32'h300; ls_be = 4'hF; ls_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic exp_ls;
         exp_ls = (k % 2 == 0);
         step();
         #1;
         check($sformatf("rr%0d.ls_gnt", k), 64'(ls_gnt), 64'(exp_ls));
         check($sformatf("rr%0d.if_gnt", k), 64'(if_gnt), 64'(!exp_ls));
         check($sformatf("rr%0d.addr", k), 64'(mem_addr), exp_ls ? 64'h300 : 64'h200);
         step();
         mem_rvalid = 1'b1; mem_rdata = 32'(k + 32'hA0);
         #1;
         check($sformatf("rr%0d.ls_rvalid", k), 64'(ls_rvalid), 64'(exp_ls));
         check($sformatf("rr%0d.if_rvalid", k), 64'(if_rvalid), 64'(!exp_ls));
         check($sformatf("rr%0d.rdata", k), exp_ls ? 64'(ls_rdata) : 64'(if_rdata), 64'(k + 32'hA0));
         step();
         mem_rvalid = 1'b0;
         #1 check_quiet($sformatf("rr%0d.idle", k));
      end
      if_req = 1'b0; ls_req = 1'b0;
      step();

      // Timeout abort: four WAIT cycles with no completion.
      if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'hFFFF_FFFF;
      step();
      #1 check("to.if_gnt", 64'(if_gnt), 64'd1);
      if_req = 1'b0;
      for (int w = 1; w <= 3; w++) begin
         step();
         #1;
         check($sformatf("to.w%0d.rvalid", w), 64'(if_rvalid), 64'd0);
         check($sformatf("to.w%0d.bus_err", w), 64'(bus_err), 64'd0);
      end
      step();
      #1;
      check("to.if_rvalid", 64'(if_rvalid), 64'd1);
      check("to.if_rdata",  64'(if_rdata),  64'd0);
      check("to.bus_err",   64'(bus_err),   64'd1);
      check("to.ls_rvalid", 64'(ls_rvalid), 64'd0);
      step();
      #1 check_quiet("to.idle");
      ls_req = 1'b1; ls_addr = 32'h600; ls_we = 1'b0;
      step();
      #1 check("to.next_gnt", 64'(ls_gnt), 64'd1);
      ls_req = 1'b0;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
      #1;
      check("to.next_rvalid", 64'(ls_rvalid), 64'd1);
      check("to.next_rdata",  64'(ls_rdata),  64'h0000_CAFE);
      step();
      mem_rvalid = 1'b0;

      // Reset in WAIT; completion arrives the cycle after reset.
      if_req = 1'b1; if_addr = 32'h700;
      step();
      #1 check("rw.if_gnt", 64'(if_gnt), 64'd1);
      if_req = 1'b0;
      step();
      rst = 1'b1;
      #1 check_reset_outputs("rw.during");
      step();
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
      #1 check_reset_outputs("rw.late");
      step();
      mem_rvalid = 1'b0;
      #1 check_quiet("rw.after");

      // Spurious completions in IDLE with no request.
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      for (int s = 0; s < 3; s++) begin
         #1 check_quiet($sformatf("spur%0d", s));
         step();
      end
      mem_rvalid = 1'b0;
      if_req = 1'b1; if_addr = 32'h800;
      step();
      #1 check("spur.gnt_after", 64'(if_gnt), 64'd1);
      if_req = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 255, max WAIT cycles before abort (1..255).
REQ-002 Clock and reset: clk in 1, single clock, all state on rising edge; rst in 1, synchronous active-high reset.
REQ-003 Instruction-fetch port (read-only): if_req in 1 request; if_addr in ADDR_W; if_gnt out 1 accept pulse; if_rvalid out 1 completion pulse; if_rdata out DATA_W.
REQ-004 Load/store port: ls_req in 1; ls_we in 1 write enable; ls_be in 4 byte enables; ls_addr in ADDR_W; ls_wdata in DATA_W; ls_gnt out 1; ls_rvalid out 1; ls_rdata out DATA_W.
REQ-005 Memory port: mem_req out 1 one-cycle issue strobe; mem_we out 1; mem_be out 4; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rvalid in 1 completion; mem_rdata in DATA_W.
REQ-006 Status: bus_err out 1, one-cycle pulse on timeout abort.

Function
REQ-007 FSM states IDLE, ISSUE, WAIT; registers owner (IF/LS), last_owner (IF/LS), wait counter (8 bit).
REQ-008 IDLE: no request -> stay IDLE; exactly one of if_req/ls_req -> that requester becomes owner, go ISSUE; both -> owner = requester not equal to last_owner, go ISSUE.
REQ-009 On IDLE->ISSUE, latch owner's addr (and for LS: we, be, wdata) into issue registers; IF issue forces mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-010 ISSUE (exactly one cycle): mem_req=1, mem_* = latched values, owner's x_gnt=1; last_owner <= owner; counter <= 0; next state WAIT.
REQ-011 Requesters hold req and payload stable until x_gnt; arbiter samples payload only on IDLE->ISSUE.
REQ-012 WAIT: mem_rvalid=1 -> owner's x_rvalid=1, x_rdata=mem_rdata (combinational pass-through, same cycle), next IDLE.
REQ-013 WAIT: mem_rvalid=0 and counter==TIMEOUT-1 -> owner's x_rvalid=1, x_rdata=0, bus_err=1, next IDLE; else counter increments.
REQ-014 mem_rvalid outside WAIT (IDLE, ISSUE) ignored: no rvalid, no state change.
REQ-015 Non-owner's gnt/rvalid always 0; non-owner rdata = 0; at most one gnt and one rvalid asserted per cycle.
REQ-016 Write completion: ls_rvalid pulses as ack; ls_rdata = mem_rdata, content undefined for requester.
REQ-017 Minimum latency: req seen in IDLE cycle N -> gnt/mem_req cycle N+1 -> rvalid earliest cycle N+2; at least one IDLE cycle between transactions.
REQ-018 mem_req deasserted in IDLE and WAIT; mem_* payload outputs hold last latched value outside ISSUE.
REQ-019 Request withdrawn before gnt (contract violation) in ISSUE/WAIT has no effect on the in-flight transaction.

Reset
REQ-020 rst=1 at rising edge: state IDLE, owner=IF, last_owner=IF (LS wins first tie), counter=0, issue registers 0.
REQ-021 During and after reset all outputs 0: if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err.
REQ-022 Reset mid-transaction (ISSUE or WAIT) aborts: no rvalid, no bus_err; late mem_rvalid afterwards ignored per REQ-014.

Verification
REQ-023 Single fetch: if_req=1, if_addr=0x0000_0040; memory returns 0x0010_0093 two cycles after mem_req -> if_gnt and mem_req in same cycle, mem_addr=0x40, mem_we=0, if_rvalid with if_rdata=0x0010_0093, ls_* silent.
REQ-024 Store: ls_req=1, ls_we=1, ls_be=4'b0011, ls_addr=0x100, ls_wdata=0xDEAD_BEEF -> mem_we=1, mem_be=4'b0011, mem_wdata=0xDEAD_BEEF, ls_rvalid pulse on mem_rvalid.
REQ-025 Contention after reset: if_req and ls_req held high for 4 transactions -> grant order LS, IF, LS, IF; each gnt exactly one cycle.
REQ-026 Timeout: TIMEOUT=4, mem_rvalid never asserted -> owner rvalid=1, rdata=0, bus_err=1 on 4th WAIT cycle; next cycle IDLE; later request serviced normally.
REQ-027 Reset during WAIT with mem_rvalid arriving one cycle after rst -> no if_rvalid/ls_rvalid, state IDLE, outputs per REQ-021.
REQ-028 Spurious mem_rvalid in IDLE with no request -> all requester outputs stay 0.
